// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS15 BER run sequencer
// and its generator/checker pair.
package prbs_pkg;

  localparam int CNT_W_DEF = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RESET = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_MEAS  = 3'd3;
  localparam state_t S_STOP  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  typedef struct packed {
    logic timeout_err;
    logic lock_lost;
    logic aborted;
  } flags_t;

  // x^15 + x^14 + 1
  localparam int          PRBS15_LEN  = 15;
  localparam logic [14:0] PRBS15_POLY = 15'h6000;
  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  function automatic logic [14:0] prbs15_step(
    input logic [14:0] s
  );
    return {s[13:0], s[14] ^ s[13]};
  endfunction

endpackage

// File: rtl/prbs_ber_sequencer_if.sv
// Control/status and link-side bundle of the BER run sequencer.
// master = software + checker side, slave = sequencer.
interface prbs_ber_sequencer_if
  import prbs_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] window_cycles;
  logic [15:0]      lock_timeout;
  logic             locked;
  logic [CNT_W-1:0] bit_errors;
  logic             prbs_reset;
  logic             ber_stop;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             lock_lost;
  logic             aborted;
  logic [CNT_W-1:0] error_count;
  logic [CNT_W-1:0] cycles_run;

  modport master (
    output start, abort, window_cycles,
    output lock_timeout, locked, bit_errors,
    input  prbs_reset, ber_stop, busy, done,
    input  timeout_err, lock_lost, aborted,
    input  error_count, cycles_run
  );

  modport slave (
    input  start, abort, window_cycles,
    input  lock_timeout, locked, bit_errors,
    output prbs_reset, ber_stop, busy, done,
    output timeout_err, lock_lost, aborted,
    output error_count, cycles_run
  );
endinterface

// File: rtl/prbs_ber_window_cnt.sv
// Loadable up/down counter, floor at 0, saturating at all-ones,
// with a programmable terminal-count compare.
module prbs_ber_window_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - ONE;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);
endmodule

// File: rtl/prbs_ber_sequencer.sv
// Run-control FSM for one PRBS15 loopback lane: reset, lock,
// timed measurement window, stop/settle and error-delta latch.
module prbs_ber_sequencer
  import prbs_pkg::*;
#(
  parameter int RST_CYCLES  = 8,
  parameter int STOP_SETTLE = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  prbs_ber_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LD =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STP_LD =
    CNT_W'(STOP_SETTLE - 1);

  state_t           state_q, state_d;
  flags_t           flags_q, flags_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             stop_q, stop_d;

  logic             ph_load, ph_inc, ph_dec, ph_tc;
  logic [CNT_W-1:0] ph_val, ph_tcv, ph_cnt;
  logic             cr_load, cr_inc, cr_tc;
  logic [CNT_W-1:0] cr_cnt;
  logic             win_end;

  // One counter serves RESET (down), WAIT_LOCK (up), STOP (down)
  assign ph_tcv = (state_q == S_WAIT)
                ? CNT_W'(bus.lock_timeout) - ONE
                : '0;

  prbs_ber_window_cnt #(.W(CNT_W)) u_phase (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .inc_i      (ph_inc),
    .dec_i      (ph_dec),
    .tc_val_i   (ph_tcv),
    .cnt_o      (ph_cnt),
    .tc_o       (ph_tc)
  );

  prbs_ber_window_cnt #(.W(CNT_W)) u_run (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cr_load),
    .load_val_i ('0),
    .inc_i      (cr_inc),
    .dec_i      (1'b0),
    .tc_val_i   (bus.window_cycles - ONE),
    .cnt_o      (cr_cnt),
    .tc_o       (cr_tc)
  );

  assign win_end = (bus.window_cycles != '0) && cr_tc;

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    base_d  = base_q;
    err_d   = err_q;
    ph_load = 1'b0;
    ph_val  = '0;
    ph_inc  = 1'b0;
    ph_dec  = 1'b0;
    cr_load = 1'b0;
    cr_inc  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.start && !bus.abort) begin
          state_d = S_RESET;
          flags_d = '0;
          err_d   = '0;
          cr_load = 1'b1;
          ph_load = 1'b1;
          ph_val  = RST_LD;
        end
      end
      (state_q == S_RESET): begin
        if (bus.abort) begin
          state_d         = S_DONE;
          flags_d.aborted = 1'b1;
        end else if (ph_tc) begin
          state_d = S_WAIT;
          ph_load = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      (state_q == S_WAIT): begin
        if (bus.abort) begin
          state_d         = S_DONE;
          flags_d.aborted = 1'b1;
        end else if (bus.locked) begin
          state_d = S_MEAS;
          base_d  = bus.bit_errors;
          cr_load = 1'b1;
        end else if (bus.lock_timeout != '0 && ph_tc) begin
          state_d             = S_STOP;
          flags_d.timeout_err = 1'b1;
          ph_load             = 1'b1;
          ph_val              = STP_LD;
        end else begin
          ph_inc = 1'b1;
        end
      end
      (state_q == S_MEAS): begin
        // a cycle with lock low is never counted
        cr_inc = bus.locked;
        if (bus.abort || !bus.locked || win_end) begin
          state_d = S_STOP;
          ph_load = 1'b1;
          ph_val  = STP_LD;
          if (bus.abort)
            flags_d.aborted = 1'b1;
          else if (!bus.locked)
            flags_d.lock_lost = 1'b1;
        end
      end
      (state_q == S_STOP): begin
        if (ph_tc) begin
          state_d = S_DONE;
          if (!flags_q.timeout_err)
            err_d = bus.bit_errors - base_q;
        end else begin
          ph_dec = 1'b1;
        end
      end
      (state_q == S_DONE): state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
    // stop stays up through DONE only when a STOP phase ran
    stop_d = (state_d == S_STOP)
          || (state_d == S_DONE && state_q == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      base_q  <= '0;
      err_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      base_q  <= base_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.prbs_reset  = !(state_q == S_WAIT
                          || state_q == S_MEAS
                          || state_q == S_STOP);
  assign bus.ber_stop    = stop_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.timeout_err = flags_q.timeout_err;
  assign bus.lock_lost   = flags_q.lock_lost;
  assign bus.aborted     = flags_q.aborted;
  assign bus.error_count = err_q;
  assign bus.cycles_run  = cr_cnt;
endmodule
